seq_alu: RTL and testbench

Parametrised multi-cycle successor to the combinational ALU, used by the accumulator datapath.
- Single-cycle logic/arithmetic ops, iterative shift-add multiply and restoring divide.
- Barrel shifts/rotates by a variable amount.
- start/ready/done handshake and a registered result with status flags.
- Sits between the accumulator/MBR operand sources and the accumulator write-back; the control sequencer stalls on !ready.

---
 rtl/seq_alu.sv | 275 +++++++++++++++++++++++++++
 tb/tb_seq_alu.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with single-cycle logic/arithmetic/shift ops,
// iterative shift-add multiply and restoring divide behind a
// start/ready/done handshake. Every output is registered.
// Optional build macro SEQ_ALU_FLAGS_EN: when defined, the status flags are
// registered; when undefined the flag ports are tied to 0.
module seq_alu #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_ovf,
  output logic             flag_dbz
);

  localparam int unsigned SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_DIV  = 4'h3;
  localparam logic [3:0] OP_SHL  = 4'h4;
  localparam logic [3:0] OP_SHR  = 4'h5;
  localparam logic [3:0] OP_ROL  = 4'h6;
  localparam logic [3:0] OP_ROR  = 4'h7;
  localparam logic [3:0] OP_AND  = 4'h8;
  localparam logic [3:0] OP_OR   = 4'h9;
  localparam logic [3:0] OP_XOR  = 4'hA;
  localparam logic [3:0] OP_NOR  = 4'hB;
  localparam logic [3:0] OP_NAND = 4'hC;
  localparam logic [3:0] OP_XNOR = 4'hD;
  localparam logic [3:0] OP_GT   = 4'hE;
  localparam logic [3:0] OP_EQ   = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;   // partial product high / remainder
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;   // multiplier / dividend -> quotient
  logic [WIDTH-1:0] opnd_q, opnd_d;       // multiplicand / divisor
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] result_hi_q, result_hi_d;

  logic [SHW-1:0]   shamt_c;
  logic [WIDTH-1:0] alu_res_c;

  logic [WIDTH:0]   mul_sum_c;
  logic [WIDTH-1:0] mul_hi_c, mul_lo_c;
  logic [WIDTH:0]   div_r2_c;
  logic             div_ge_c;
  logic [WIDTH-1:0] div_rem_c, div_quo_c;

  assign shamt_c = operand2[SHW-1:0];

  // Single-cycle result for every opcode except multiply/divide
  always_comb begin
    alu_res_c = '0;
    case (opcode)
      OP_ADD:  alu_res_c = operand1 + operand2;
      OP_SUB:  alu_res_c = operand1 - operand2;
      OP_SHL:  alu_res_c = operand1 << shamt_c;
      OP_SHR:  alu_res_c = operand1 >> shamt_c;
      OP_ROL:  alu_res_c = WIDTH'(({operand1, operand1} << shamt_c) >> WIDTH);
      OP_ROR:  alu_res_c = WIDTH'({operand1, operand1} >> shamt_c);
      OP_AND:  alu_res_c = operand1 & operand2;
      OP_OR:   alu_res_c = operand1 | operand2;
      OP_XOR:  alu_res_c = operand1 ^ operand2;
      OP_NOR:  alu_res_c = ~(operand1 | operand2);
      OP_NAND: alu_res_c = ~(operand1 & operand2);
      OP_XNOR: alu_res_c = ~(operand1 ^ operand2);
      OP_GT:   alu_res_c = WIDTH'(operand1 > operand2);
      OP_EQ:   alu_res_c = WIDTH'(operand1 == operand2);
      default: alu_res_c = '0;
    endcase
  end

  // One shift-add multiply step and one restoring-divide step
  always_comb begin
    mul_sum_c = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    mul_hi_c  = mul_sum_c[WIDTH:1];
    mul_lo_c  = {mul_sum_c[0], acc_lo_q[WIDTH-1:1]};
    div_r2_c  = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_ge_c  = div_r2_c >= {1'b0, opnd_q};
    div_rem_c = div_ge_c ? WIDTH'(div_r2_c - {1'b0, opnd_q}) : div_r2_c[WIDTH-1:0];
    div_quo_c = {acc_lo_q[WIDTH-2:0], div_ge_c};
  end

  // Next-state and output decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_hi_d    = acc_hi_q;
    acc_lo_d    = acc_lo_q;
    opnd_d      = opnd_q;
    ready_d     = ready_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (opcode == OP_MUL) begin
            state_d  = MUL;
            cnt_d    = SHW'(WIDTH - 1);
            acc_hi_d = '0;
            acc_lo_d = operand2;
            opnd_d   = operand1;
            ready_d  = 1'b0;
            busy_d   = 1'b1;
          end else if (opcode == OP_DIV && operand2 != '0) begin
            state_d  = DIV;
            cnt_d    = SHW'(WIDTH - 1);
            acc_hi_d = '0;
            acc_lo_d = operand1;
            opnd_d   = operand2;
            ready_d  = 1'b0;
            busy_d   = 1'b1;
          end else if (opcode == OP_DIV) begin
            // divide by zero completes immediately without iterating
            result_d    = '1;
            result_hi_d = operand1;
            done_d      = 1'b1;
          end else begin
            result_d    = alu_res_c;
            result_hi_d = '0;
            done_d      = 1'b1;
          end
        end
      end
      MUL: begin
        acc_hi_d = mul_hi_c;
        acc_lo_d = mul_lo_c;
        if (cnt_q == '0) begin
          state_d     = IDLE;
          ready_d     = 1'b1;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          result_d    = mul_lo_c;
          result_hi_d = mul_hi_c;
        end else begin
          cnt_d = cnt_q - SHW'(1);
        end
      end
      DIV: begin
        acc_hi_d = div_rem_c;
        acc_lo_d = div_quo_c;
        if (cnt_q == '0) begin
          state_d     = IDLE;
          ready_d     = 1'b1;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          result_d    = div_quo_c;
          result_hi_d = div_rem_c;
        end else begin
          cnt_d = cnt_q - SHW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_hi_q    <= '0;
      acc_lo_q    <= '0;
      opnd_q      <= '0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_hi_q    <= acc_hi_d;
      acc_lo_q    <= acc_lo_d;
      opnd_q      <= opnd_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
    end
  end

  assign ready     = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign result_hi = result_hi_q;

`ifdef SEQ_ALU_FLAGS_EN
  logic zero_q, zero_d;
  logic carry_q, carry_d;
  logic ovf_q, ovf_d;
  logic dbz_q, dbz_d;
  logic add_carry_c;

  // Status flags, refreshed together with the result on every completion
  always_comb begin
    add_carry_c = 1'(({1'b0, operand1} + {1'b0, operand2}) >> WIDTH);
    zero_d  = zero_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    dbz_d   = dbz_q;
    if (done_d) begin
      zero_d  = (result_d == '0);
      carry_d = 1'b0;
      ovf_d   = 1'b0;
      dbz_d   = 1'b0;
      case (state_q)
        IDLE: begin
          if (opcode == OP_ADD) carry_d = add_carry_c;
          if (opcode == OP_SUB) carry_d = (operand1 < operand2);
          if (opcode == OP_DIV) dbz_d   = 1'b1;
        end
        MUL:     ovf_d = (result_hi_d != '0);
        default: ;
      endcase
    end
  end

  // Flag registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      zero_q  <= zero_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      dbz_q   <= dbz_d;
    end
  end

  assign flag_zero  = zero_q;
  assign flag_carry = carry_q;
  assign flag_ovf   = ovf_q;
  assign flag_dbz   = dbz_q;
`else
  assign flag_zero  = 1'b0;
  assign flag_carry = 1'b0;
  assign flag_ovf   = 1'b0;
  assign flag_dbz   = 1'b0;
`endif

endmodule

// File: tb/tb_seq_alu.sv
// Testbench for seq_alu: directed scenarios plus randomized operations,
// compared against an arithmetic reference model.
module tb_seq_alu;

  localparam int unsigned W = 16;

`ifdef SEQ_ALU_FLAGS_EN
  localparam bit FLAGS_ON = 1'b1;
`else
  localparam bit FLAGS_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [3:0]   opcode;
  logic [W-1:0] operand1, operand2;
  logic         ready, busy, done;
  logic [W-1:0] result, result_hi;
  logic         flag_zero, flag_carry, flag_ovf, flag_dbz;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [15:0] res;
    logic [15:0] hi;
    bit          z, c, o, d;
    int          lat;
  } exp_t;

  seq_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .opcode    (opcode),
    .operand1  (operand1),
    .operand2  (operand2),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .result_hi (result_hi),
    .flag_zero (flag_zero),
    .flag_carry(flag_carry),
    .flag_ovf  (flag_ovf),
    .flag_dbz  (flag_dbz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Reference behaviour computed with plain integer arithmetic
  function automatic exp_t model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    int unsigned x, y, sh, p;
    x = 32'(a);
    y = 32'(b);
    sh = y % 16;
    e.res = '0; e.hi = '0; e.z = 0; e.c = 0; e.o = 0; e.d = 0; e.lat = 0;
    case (op)
      4'h0: begin p = x + y; e.res = 16'(p); e.c = (p > 32'hFFFF); end
      4'h1: begin e.res = 16'(x - y); e.c = (x < y); end
      4'h2: begin p = x * y; e.res = 16'(p); e.hi = 16'(p >> 16); e.o = (e.hi != 0); e.lat = W; end
      4'h3: begin
        if (y == 0) begin e.res = 16'hFFFF; e.hi = a; e.d = 1; end
        else begin e.res = 16'(x / y); e.hi = 16'(x % y); e.lat = W; end
      end
      4'h4: e.res = 16'(x << sh);
      4'h5: e.res = 16'(x >> sh);
      4'h6: e.res = 16'((x << sh) | (x >> (16 - sh)));
      4'h7: e.res = 16'((x >> sh) | (x << (16 - sh)));
      4'h8: e.res = a & b;
      4'h9: e.res = a | b;
      4'hA: e.res = a ^ b;
      4'hB: e.res = ~(a | b);
      4'hC: e.res = ~(a & b);
      4'hD: e.res = ~(a ^ b);
      4'hE: e.res = (x > y) ? 16'd1 : 16'd0;
      default: e.res = (x == y) ? 16'd1 : 16'd0;
    endcase
    e.z = (e.res == 0);
    if (!FLAGS_ON) begin e.z = 0; e.c = 0; e.o = 0; e.d = 0; end
    return e;
  endfunction

  function automatic logic [31:0] flags_now();
    return 32'({flag_zero, flag_carry, flag_ovf, flag_dbz});
  endfunction

  function automatic logic [31:0] flags_exp(input exp_t e);
    return 32'({e.z, e.c, e.o, e.d});
  endfunction

  // Issue one op from an idle DUT (called #1 after a rising edge)
  task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input bit disturb, input string tag);
    exp_t e;
    int lat, busy_cyc;
    e = model(op, a, b);
    opcode = op; operand1 = a; operand2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    busy_cyc = 0;
    while (!done && lat < 40) begin
      if (busy && !ready) busy_cyc++;
      start = disturb && (lat < 4);
      if (disturb) begin
        opcode = 4'h0; operand1 = 16'($urandom); operand2 = 16'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    chk({tag, " latency"}, 32'(lat), 32'(e.lat));
    chk({tag, " busy_cycles"}, 32'(busy_cyc), 32'(e.lat));
    chk({tag, " result"}, 32'(result), 32'(e.res));
    chk({tag, " result_hi"}, 32'(result_hi), 32'(e.hi));
    chk({tag, " flags"}, flags_now(), flags_exp(e));
    chk({tag, " ready_busy"}, 32'({ready, busy}), 32'(2'b10));
    @(posedge clk); #1;
    chk({tag, " done_once"}, 32'(done), 32'(0));
    chk({tag, " hold"}, 32'({result_hi, result}), {e.hi, e.res});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (%0d checks)", n_chk);
    $fatal(1);
  end

  initial begin
    exp_t e;
    int nd;
    logic [3:0] op;
    logic [15:0] a, b;

    reset_n = 1'b0; start = 1'b0; opcode = '0; operand1 = '0; operand2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset ready_busy_done", 32'({ready, busy, done}), 32'(3'b100));
    chk("reset result", 32'(result), 32'(0));
    chk("reset result_hi", 32'(result_hi), 32'(0));
    chk("reset flags", flags_now(), 32'(0));
    reset_n = 1'b1;
    @(posedge clk); #1;

    run_op(4'h0, 16'hFFFF, 16'h0001, 1'b0, "add_wrap");
    run_op(4'h2, 16'h1234, 16'h0100, 1'b0, "mul");
    run_op(4'h3, 16'd100, 16'd7, 1'b0, "div");
    run_op(4'h3, 16'd5, 16'd0, 1'b0, "div0");
    run_op(4'h3, 16'hFFFF, 16'h0001, 1'b0, "div_by1");
    run_op(4'h2, 16'hFFFF, 16'hFFFF, 1'b0, "mul_max");
    run_op(4'h4, 16'h1234, 16'h0000, 1'b0, "shl0");

    // back-to-back rol then shr
    e = model(4'h6, 16'h8001, 16'h0004);
    opcode = 4'h6; operand1 = 16'h8001; operand2 = 16'h0004; start = 1'b1;
    @(posedge clk); #1;
    chk("b2b rol done", 32'({done, ready}), 32'(2'b11));
    chk("b2b rol result", 32'(result), 32'(e.res));
    e = model(4'h5, 16'h8000, 16'd15);
    opcode = 4'h5; operand1 = 16'h8000; operand2 = 16'd15;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b shr done", 32'(done), 32'(1));
    chk("b2b shr result", 32'(result), 32'(e.res));
    @(posedge clk); #1;
    chk("b2b idle done", 32'(done), 32'(0));

    run_op(4'h2, 16'hBEEF, 16'h1357, 1'b1, "mul_disturb");
    run_op(4'h3, 16'hF00D, 16'h0033, 1'b1, "div_disturb");

    // reset in the middle of a multiply
    opcode = 4'h2; operand1 = 16'hABCD; operand2 = 16'h1234; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("midrst ready_busy_done", 32'({ready, busy, done}), 32'(3'b100));
    chk("midrst result", 32'({result_hi, result}), 32'(0));
    chk("midrst flags", flags_now(), 32'(0));
    @(posedge clk); #1;
    reset_n = 1'b1;
    nd = 0;
    repeat (W + 4) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    chk("midrst no_done", 32'(nd), 32'(0));
    run_op(4'h0, 16'd2, 16'd3, 1'b0, "add_after_rst");

    // randomized single ops and multi-cycle ops
    for (int i = 0; i < 150; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = 16'($urandom);
      b  = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
      run_op(op, a, b, ($urandom_range(0, 3) == 0), "rnd");
    end

    // randomized back-to-back single-cycle stream
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 13));
      if (op >= 4'd2) op = op + 4'd2;
      a = 16'($urandom);
      b = 16'($urandom);
      e = model(op, a, b);
      opcode = op; operand1 = a; operand2 = b; start = 1'b1;
      @(posedge clk); #1;
      chk("stream done_ready", 32'({done, ready}), 32'(2'b11));
      chk("stream result", 32'({result_hi, result}), {e.hi, e.res});
      chk("stream flags", flags_now(), flags_exp(e));
    end
    start = 1'b0;
    @(posedge clk); #1;
    chk("stream end done", 32'(done), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
